studio2_keypad: RTL

- Keypad front end for the Studio II core; sits directly upstream of the cdp1802 EF inputs.
- Converts MiSTer ps2_key events into two 10-key pressed bitmaps (keypad 1, keypad 2).
- Latches the key-select value the CPU writes with OUT 2.
- Drives active-low EF3 (keypad 1) and EF4 (keypad 2), high when the selected key is not held.

---
 rtl/studio2_keypad_pkg.sv | 43 ++++
 rtl/studio2_keypad_if.sv | 21 ++
 rtl/studio2_key_hold.sv | 39 +++
 rtl/studio2_keypad.sv | 91 +++++++++
 4 files changed

// File: rtl/studio2_keypad_pkg.sv
// Shared types, scancode tables and the scancode decoder for the Studio II keypad front end.
package studio2_pkg;

  typedef logic [3:0] key_idx_t;
  typedef enum logic {PAD1, PAD2} pad_e;

  localparam key_idx_t KEY_NONE = 4'hF;

  // Element i holds the scancode of key i.
  localparam logic [9:0][7:0] KP1_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                           8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [9:0][7:0] KP2_CODES = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                           8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

  typedef struct packed {
    logic     hit;
    pad_e     pad;
    key_idx_t idx;
  } key_dec_t;

  function automatic key_dec_t decode_scancode(logic ext, logic [7:0] code);
    key_dec_t d;
    d.hit = 1'b0;
    d.pad = PAD1;
    d.idx = KEY_NONE;
    if (!ext) begin
      for (int i = 0; i < 10; i++) begin
        if (code == KP1_CODES[i]) begin
          d.hit = 1'b1;
          d.pad = PAD1;
          d.idx = key_idx_t'(i);
        end
        if (code == KP2_CODES[i]) begin
          d.hit = 1'b1;
          d.pad = PAD2;
          d.idx = key_idx_t'(i);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/studio2_keypad_if.sv
// Bundle of ps2/CPU inputs and EF/bitmap outputs of the keypad front end.
interface studio2_keypad_if;
  logic [10:0] ps2_key;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  io_dout;
  logic        ef3_n;
  logic        ef4_n;
  logic [3:0]  key_sel;
  logic [9:0]  kp1_state;
  logic [9:0]  kp2_state;

  modport master (
    output ps2_key, io_out, io_n, io_dout,
    input  ef3_n, ef4_n, key_sel, kp1_state, kp2_state
  );
  modport slave (
    input  ps2_key, io_out, io_n, io_dout,
    output ef3_n, ef4_n, key_sel, kp1_state, kp2_state
  );
endinterface

// File: rtl/studio2_key_hold.sv
// Per-key press stretcher: keeps a key visible for HOLD_CYCLES after it was pressed.
module studio2_key_hold #(
  parameter int unsigned HOLD_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic ev,
  input  logic pressed,
  output logic held
);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          held_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      held_q <= 1'b0;
    end else if (ev && pressed) begin
      cnt_q  <= CW'(HOLD_CYCLES);
      pend_q <= 1'b0;
      held_q <= 1'b1;
    end else begin
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      // A release landing on the final count expires together with the counter.
      if ((ev && cnt_q <= CW'(1)) || (pend_q && cnt_q == CW'(1))) begin
        held_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (ev) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign held = held_q;
endmodule

// File: rtl/studio2_keypad.sv
// Studio II keypad front end: ps2 events -> two key bitmaps, OUT 2 select latch, EF3/EF4.
// Optional KEYPAD_HOLD_STRETCH_EN keeps each press visible for at least HOLD_CYCLES.
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES = 16'd65535
) (
  input logic             clk,
  input logic             reset,
  studio2_keypad_if.slave kp
);
  logic        toggle_q;
  logic [9:0]  kp1_q, kp2_q;
  key_idx_t    sel_q;
  logic        ef3_q, ef4_q;
  key_dec_t    dec;
  logic [9:0]  ev1, ev2;
  logic        sel_wr;
  logic [15:0] kp1_ext, kp2_ext;

  always_comb begin
    dec = decode_scancode(kp.ps2_key[8], kp.ps2_key[7:0]);
    ev1 = '0;
    ev2 = '0;
    if (kp.ps2_key[10] != toggle_q && dec.hit) begin
      if (dec.pad == PAD1) ev1 = 10'b1 << dec.idx;
      else                 ev2 = 10'b1 << dec.idx;
    end
  end

  assign sel_wr  = kp.io_out && (kp.io_n == 3'd2);
  // Zero-extended so out-of-range selects index a defined 0.
  assign kp1_ext = {6'b0, kp1_q};
  assign kp2_ext = {6'b0, kp2_q};

  always_ff @(posedge clk) begin
    toggle_q <= kp.ps2_key[10];
    if (reset) begin
      sel_q <= KEY_NONE;
      ef3_q <= 1'b1;
      ef4_q <= 1'b1;
    end else begin
      if (sel_wr) sel_q <= kp.io_dout[3:0];
      ef3_q <= ~(sel_q <= 4'd9 && kp1_ext[sel_q]);
      ef4_q <= ~(sel_q <= 4'd9 && kp2_ext[sel_q]);
    end
  end

`ifdef KEYPAD_HOLD_STRETCH_EN
  for (genvar i = 0; i < 10; i++) begin : g_hold
    studio2_key_hold #(
      .HOLD_CYCLES(32'(HOLD_CYCLES))
    ) u_hold1 (
      .clk    (clk),
      .reset  (reset),
      .ev     (ev1[i]),
      .pressed(kp.ps2_key[9]),
      .held   (kp1_q[i])
    );
    studio2_key_hold #(
      .HOLD_CYCLES(32'(HOLD_CYCLES))
    ) u_hold2 (
      .clk    (clk),
      .reset  (reset),
      .ev     (ev2[i]),
      .pressed(kp.ps2_key[9]),
      .held   (kp2_q[i])
    );
  end
  logic unused_bits;
  assign unused_bits = ^kp.io_dout[7:4];
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      kp1_q <= '0;
      kp2_q <= '0;
    end else begin
      kp1_q <= (kp1_q & ~ev1) | (ev1 & {10{kp.ps2_key[9]}});
      kp2_q <= (kp2_q & ~ev2) | (ev2 & {10{kp.ps2_key[9]}});
    end
  end
  logic unused_bits;
  assign unused_bits = ^{kp.io_dout[7:4], HOLD_CYCLES};
`endif

  assign kp.ef3_n     = ef3_q;
  assign kp.ef4_n     = ef4_q;
  assign kp.key_sel   = sel_q;
  assign kp.kp1_state = kp1_q;
  assign kp.kp2_state = kp2_q;
endmodule
